// File: rtl/data_buffer.sv
// Shared 8-bit circular FIFO between the AHB register side and the USB packet side.
// Heads are first-word-fall-through; occupancy is a registered count.
module data_buffer #(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear,
    input  logic       store_tx_data,
    input  logic [7:0] tx_data,
    input  logic       get_rx_data,
    output logic [7:0] rx_data,
    input  logic       store_rx_packet_data,
    input  logic [7:0] rx_packet_data,
    input  logic       get_tx_packet_data,
    output logic [7:0] tx_packet_data,
    output logic [6:0] buffer_occupancy
);

    localparam int DATA_W = 8;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [6:0] FULL_CNT = 7'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [6:0]        count_q, count_d;

    logic              push, pop;
    logic              push_ok, pop_ok;
    logic [DATA_W-1:0] wr_byte;
    logic [DATA_W-1:0] head;

    // Request decode: USB receiver wins the write port over the AHB side.
    always_comb begin
        push    = store_rx_packet_data | store_tx_data;
        pop     = get_rx_data | get_tx_packet_data;
        wr_byte = store_rx_packet_data ? rx_packet_data : tx_data;
        pop_ok  = pop && (count_q != 7'd0);
        // A full buffer still accepts a byte when a pop frees a slot this cycle.
        push_ok = push && ((count_q != FULL_CNT) || pop_ok);
    end

    // Next-state for pointers and count; clear dominates any traffic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = 7'd0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + 7'd1;
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - 7'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 7'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; an empty count masks whatever it holds.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_byte;
        end
    end

    always_comb begin
        head = (count_q != 7'd0) ? mem_q[rd_ptr_q] : 8'h00;
    end

    assign rx_data          = head;
    assign tx_packet_data   = head;
    assign buffer_occupancy = count_q;

endmodule

// File: tb/tb_data_buffer.sv
// Directed bench for data_buffer: linear sequence of steps with hand-computed expectations.
module tb_data_buffer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       clear;
    logic       store_tx_data;
    logic [7:0] tx_data;
    logic       get_rx_data;
    logic [7:0] rx_data;
    logic       store_rx_packet_data;
    logic [7:0] rx_packet_data;
    logic       get_tx_packet_data;
    logic [7:0] tx_packet_data;
    logic [6:0] buffer_occupancy;

    int vectors = 0;
    int miscompares = 0;

    data_buffer #(.DEPTH(64)) dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .clear                (clear),
        .store_tx_data        (store_tx_data),
        .tx_data              (tx_data),
        .get_rx_data          (get_rx_data),
        .rx_data              (rx_data),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .tx_packet_data       (tx_packet_data),
        .buffer_occupancy     (buffer_occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [6:0] occ, input logic [7:0] hd);
        chk({tag, ".occ"}, {1'b0, buffer_occupancy}, {1'b0, occ});
        chk({tag, ".rx_data"}, rx_data, hd);
        chk({tag, ".tx_pkt"}, tx_packet_data, hd);
    endtask

    // Advance one edge, then release all request strobes away from the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        clear                = 1'b0;
        store_tx_data        = 1'b0;
        store_rx_packet_data = 1'b0;
        get_rx_data          = 1'b0;
        get_tx_packet_data   = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] b);
        store_tx_data = 1'b1;
        tx_data       = b;
        cyc();
    endtask

    task automatic push_rx(input logic [7:0] b);
        store_rx_packet_data = 1'b1;
        rx_packet_data       = b;
        cyc();
    endtask

    initial begin
        n_rst = 1'b0;
        clear = 1'b0;
        store_tx_data = 1'b0;
        tx_data = 8'h00;
        get_rx_data = 1'b0;
        store_rx_packet_data = 1'b0;
        rx_packet_data = 8'h00;
        get_tx_packet_data = 1'b0;
        cyc();
        cyc();
        chk_state("reset", 7'd0, 8'h00);
        n_rst = 1'b1;
        cyc();
        chk_state("post_reset_idle", 7'd0, 8'h00);

        // Three AHB pushes, drained by the USB transmitter.
        push_tx(8'hA1);
        chk_state("first_push", 7'd1, 8'hA1);
        push_tx(8'hB2);
        store_tx_data = 1'b1;
        tx_data       = 8'hC3;
        #1;
        chk({"occ_not_comb"}, {1'b0, buffer_occupancy}, 8'd2);
        cyc();
        chk_state("three_pushed", 7'd3, 8'hA1);
        get_tx_packet_data = 1'b1;
        #1;
        chk("pop0_same_cycle", tx_packet_data, 8'hA1);
        cyc();
        get_tx_packet_data = 1'b1;
        #1;
        chk("pop1_same_cycle", tx_packet_data, 8'hB2);
        cyc();
        get_tx_packet_data = 1'b1;
        #1;
        chk("pop2_same_cycle", tx_packet_data, 8'hC3);
        cyc();
        chk_state("drained", 7'd0, 8'h00);

        // Empty-buffer pop is ignored; push+pop at empty performs only the push.
        get_rx_data = 1'b1;
        cyc();
        chk_state("pop_empty", 7'd0, 8'h00);
        store_tx_data = 1'b1;
        tx_data       = 8'h5A;
        get_rx_data   = 1'b1;
        cyc();
        chk_state("push_pop_empty", 7'd1, 8'h5A);
        get_rx_data = 1'b1;
        cyc();
        chk_state("pop_5a", 7'd0, 8'h00);

        // Both sides push together: USB byte wins, AHB byte dropped.
        store_tx_data        = 1'b1;
        tx_data              = 8'h11;
        store_rx_packet_data = 1'b1;
        rx_packet_data       = 8'h22;
        cyc();
        chk_state("dual_push", 7'd1, 8'h22);
        get_rx_data        = 1'b1;
        get_tx_packet_data = 1'b1;
        cyc();
        chk_state("dual_pop_one_entry", 7'd0, 8'h00);

        // Simultaneous pops from both sides remove exactly one entry.
        push_rx(8'h31);
        push_rx(8'h32);
        get_rx_data        = 1'b1;
        get_tx_packet_data = 1'b1;
        cyc();
        chk_state("dual_pop_of_two", 7'd1, 8'h32);
        get_rx_data = 1'b1;
        cyc();

        // Fill to full, overflow push dropped, drain in order.
        for (int i = 0; i < 64; i++) push_rx(8'(i));
        chk_state("full", 7'd64, 8'h00);
        push_rx(8'hEE);
        chk_state("overflow_dropped", 7'd64, 8'h00);
        for (int i = 0; i < 64; i++) begin
            get_rx_data = 1'b1;
            #1;
            chk($sformatf("drain_%0d", i), rx_data, 8'(i));
            cyc();
        end
        chk_state("drained_full", 7'd0, 8'h00);

        // Push and pop together while full: count holds, new byte comes out last.
        for (int i = 0; i < 64; i++) push_tx(8'(i + 64));
        chk_state("refull", 7'd64, 8'h40);
        store_tx_data      = 1'b1;
        tx_data            = 8'hFF;
        get_tx_packet_data = 1'b1;
        cyc();
        chk_state("full_push_pop", 7'd64, 8'h41);
        for (int i = 0; i < 63; i++) begin
            get_tx_packet_data = 1'b1;
            #1;
            chk($sformatf("drain2_%0d", i), tx_packet_data, 8'(i + 65));
            cyc();
        end
        chk_state("last_is_new", 7'd1, 8'hFF);
        get_tx_packet_data = 1'b1;
        cyc();
        chk_state("drained2", 7'd0, 8'h00);

        // Clear overrides a concurrent push.
        for (int i = 0; i < 10; i++) push_tx(8'(8'h80 + i));
        chk_state("ten", 7'd10, 8'h80);
        clear         = 1'b1;
        store_tx_data = 1'b1;
        tx_data       = 8'h99;
        cyc();
        chk_state("clear_with_push", 7'd0, 8'h00);
        push_tx(8'h77);
        chk_state("after_clear_push", 7'd1, 8'h77);
        get_rx_data = 1'b1;
        cyc();

        // Reset mid-fill abandons contents, even with a push pending.
        for (int i = 0; i < 5; i++) push_rx(8'(8'hC0 + i));
        chk_state("five", 7'd5, 8'hC0);
        n_rst                = 1'b0;
        store_rx_packet_data = 1'b1;
        rx_packet_data       = 8'hDD;
        cyc();
        chk_state("reset_mid_fill", 7'd0, 8'h00);
        n_rst = 1'b1;
        push_rx(8'h3C);
        chk_state("after_reset_push", 7'd1, 8'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
